// File: rtl/adder_pkg.sv
// Shared definitions for the sequential multiword adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

  // Width of one datapath word; the adder and operand slicing use this.
  localparam int WORD_W = 32;

  // Control states of the word-serial sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_select_adder_32bit.sv
// 32-bit carry-select adder: ripple low half, precomputed upper half for both carries.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
// Ports: a, b = operands; c_in = carry in; sum = a+b+c_in mod 2^32; c_out = carry out.
module carry_select_adder_32bit
  import adder_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in,
  output logic [WORD_W-1:0] sum,
  output logic              c_out
);

  localparam int HALF = WORD_W / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum0;
  logic [HALF:0] hi_sum1;

  assign lo_sum  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, c_in};
  // Upper half is evaluated for both possible carries, the low carry picks one.
  assign hi_sum0 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]};
  assign hi_sum1 = {1'b0, a[WORD_W-1:HALF]} + {1'b0, b[WORD_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};

  always_comb begin
    sum   = {hi_sum0[HALF-1:0], lo_sum[HALF-1:0]};
    c_out = hi_sum0[HALF];
    if (lo_sum[HALF]) begin
      sum   = {hi_sum1[HALF-1:0], lo_sum[HALF-1:0]};
      c_out = hi_sum1[HALF];
    end
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial add/subtract of NUM_WORDS x 32-bit operands through one shared 32-bit adder, LSW first.
// Latency: out_valid rises NUM_WORDS+1 cycles after the accepting edge.
// Backpressure: one request in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: in_valid/in_ready/in_a/in_b/in_sub/in_cin = request; out_valid/out_ready/out_sum/out_cout = result;
//        busy = operation in RUN or DONE; clk/rst_n = clock and synchronous active-low reset.
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_a,
  input  logic [WORD_W*NUM_WORDS-1:0] in_b,
  input  logic                        in_sub,
  input  logic                        in_cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_sum,
  output logic                        out_cout,
  output logic                        busy
);

  localparam int                OP_W     = WORD_W * NUM_WORDS;
  localparam int                IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    b_q;
  logic [OP_W-1:0]    result_q;
  logic               out_valid_q;

  logic [WORD_W-1:0]  a_word;
  logic [WORD_W-1:0]  b_word;
  logic [WORD_W-1:0]  sum_word_d;
  logic               carry_d;

  assign a_word = a_q[idx_q*WORD_W +: WORD_W];
  assign b_word = b_q[idx_q*WORD_W +: WORD_W];

  carry_select_adder_32bit u_csa (
    .a     (a_word),
    .b     (b_word),
    .c_in  (carry_q),
    .sum   (sum_word_d),
    .c_out (carry_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B and force the initial carry.
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*WORD_W +: WORD_W] <= sum_word_d;
          carry_q                          <= carry_d;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle only raises out_valid; the hand-off happens afterwards.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = result_q;
  // The carry register holds the final top-word carry once RUN completes.
  assign out_cout  = carry_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq with NUM_WORDS=4.
// Latency: checks out_valid arrives exactly NUM_WORDS+1 cycles after acceptance.
// Backpressure: exercises held out_ready=0, back-to-back requests and mid-RUN reset.
module tb_multiword_add_seq;

  localparam int NW = 4;
  localparam int W  = 32 * NW;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  multiword_add_seq #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " in_ready"}, W'(in_ready), W'(1));
  endtask

  // Returns the number of cycles from the accepting edge to out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    tick();
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    wait_ready(tag);
    tick();
    in_valid = 1'b0;
    chk({tag, " busy"}, W'(busy), W'(1));
    wait_valid(lat);
    chk({tag, " latency"}, W'(lat), W'(NW + 1));
    chk({tag, " sum"}, out_sum, exp_sum);
    chk({tag, " cout"}, W'(out_cout), W'(exp_cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " post valid"}, W'(out_valid), W'(0));
    chk({tag, " post ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] bb_a   [3];
    logic [W-1:0] bb_b   [3];
    logic         bb_sub [3];
    logic         bb_cin [3];
    logic [W-1:0] bb_sum [3];
    logic         bb_co  [3];
    int           lat;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst busy", W'(busy), W'(0));
    chk("rst in_ready", W'(in_ready), W'(1));
    chk("rst out_sum", out_sum, '0);
    chk("rst out_cout", W'(out_cout), W'(0));

    // Carry out of word 0 into word 1.
    run_op("add_carry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
           128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
    // Full-width overflow with carry-in.
    run_op("add_ones", ONES, ONES, 1'b0, 1'b1, ONES, 1'b1);
    run_op("sub_5_7", 128'h5, 128'h7, 1'b1, 1'b0, ONES - 128'h1, 1'b0);
    run_op("sub_7_5", 128'h7, 128'h5, 1'b1, 1'b0, 128'h2, 1'b1);
    // in_cin must be ignored for subtraction.
    run_op("sub_cin", 128'h7, 128'h5, 1'b1, 1'b1, 128'h2, 1'b1);
    // Carry chain through every word wraps to zero.
    run_op("add_wrap", ONES, '0, 1'b0, 1'b1, '0, 1'b1);
    run_op("add_mixed", 128'h0000_0001_8000_0000_7FFF_FFFF_FFFF_FFFF,
           128'h0000_0002_8000_0000_0000_0000_0000_0001, 1'b0, 1'b0,
           128'h0000_0004_0000_0000_8000_0000_0000_0000, 1'b0);

    // Hold the result with out_ready low while the request side churns.
    in_a = 128'h7; in_b = 128'h5; in_sub = 1'b1; in_cin = 1'b0; in_valid = 1'b1;
    wait_ready("hold");
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("hold latency", W'(lat), W'(NW + 1));
    held = out_sum;
    chk("hold sum", held, 128'h2);
    for (int i = 0; i < 10; i++) begin
      in_a = {4{$urandom()}}; in_b = {4{$urandom()}};
      in_sub = ~in_sub; in_cin = ~in_cin; in_valid = ~in_valid;
      tick();
      chk("hold valid", W'(out_valid), W'(1));
      chk("hold stable sum", out_sum, 128'h2);
      chk("hold cout", W'(out_cout), W'(1));
      chk("hold in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold xfer valid", W'(out_valid), W'(0));
    chk("hold xfer in_ready", W'(in_ready), W'(1));
    tick();
    chk("hold single xfer", W'(out_valid), W'(0));

    // Reset while RUN is on word index 2.
    in_a = ONES; in_b = ONES; in_sub = 1'b0; in_cin = 1'b1; in_valid = 1'b1;
    wait_ready("rst_run");
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_run out_valid", W'(out_valid), W'(0));
    chk("rst_run busy", W'(busy), W'(0));
    chk("rst_run in_ready", W'(in_ready), W'(1));
    chk("rst_run out_sum", out_sum, '0);
    chk("rst_run out_cout", W'(out_cout), W'(0));
    repeat (8) begin
      tick();
      chk("rst_run no result", W'(out_valid), W'(0));
    end
    run_op("after_rst", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
           128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);

    // Back-to-back requests with in_valid and out_ready both held high.
    bb_a[0] = 128'h1;  bb_b[0] = 128'h2; bb_sub[0] = 1'b0; bb_cin[0] = 1'b0; bb_sum[0] = 128'h3; bb_co[0] = 1'b0;
    bb_a[1] = 128'hA;  bb_b[1] = 128'h3; bb_sub[1] = 1'b1; bb_cin[1] = 1'b0; bb_sum[1] = 128'h7; bb_co[1] = 1'b1;
    bb_a[2] = ONES;    bb_b[2] = '0;     bb_sub[2] = 1'b0; bb_cin[2] = 1'b1; bb_sum[2] = '0;    bb_co[2] = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = bb_a[k]; in_b = bb_b[k]; in_sub = bb_sub[k]; in_cin = bb_cin[k];
      chk("b2b ready gap", W'(in_ready), W'(1));
      wait_ready("b2b");
      tick();
      if (k == 2) in_valid = 1'b0;
      chk("b2b busy", W'(busy), W'(1));
      wait_valid(lat);
      chk("b2b latency", W'(lat), W'(NW + 1));
      chk("b2b no same-cycle ready", W'(in_ready), W'(0));
      chk("b2b sum", out_sum, bb_sum[k]);
      chk("b2b cout", W'(out_cout), W'(bb_co[k]));
      tick();
      chk("b2b xfer valid", W'(out_valid), W'(0));
    end
    out_ready = 1'b0;
    tick();
    chk("b2b idle", W'(busy), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 4, number of 32-bit words per operand (legal 2..8).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request carries valid operands.
REQ-005 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-006 SHALL have port in_a, input, 32*NUM_WORDS, operand A, word 0 = bits [31:0].
REQ-007 SHALL have port in_b, input, 32*NUM_WORDS, operand B.
REQ-008 SHALL have port in_sub, input, 1, 1 = A-B, 0 = A+B.
REQ-009 SHALL have port in_cin, input, 1, carry-in for add; ignored when in_sub=1.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port out_sum, output, 32*NUM_WORDS, result.
REQ-013 SHALL have port out_cout, output, 1, carry out of top word (for sub: 1 = no borrow).
REQ-014 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-015 SHALL use one 32-bit carry-select adder instance, time-shared across words, one word per cycle, LSW first.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE after word NUM_WORDS-1; DONE->IDLE on out_ready.
REQ-017 SHALL assert in_ready only in IDLE; a request is accepted only on in_valid&&in_ready.
REQ-018 SHALL register in_a, in_b (B inverted when in_sub=1) and initial carry (1 when in_sub=1, else in_cin) at acceptance.
REQ-019 SHALL keep a word index counter 0..NUM_WORDS-1, cleared on acceptance, incremented each RUN cycle.
REQ-020 SHALL feed the adder carry-in from a carry register that takes the adder c_out each RUN cycle.
REQ-021 SHALL write the adder sum to word [index] of the result register each RUN cycle.
REQ-022 SHALL have latency exactly NUM_WORDS+1 cycles from acceptance edge to out_valid=1.
REQ-023 SHALL hold out_valid, out_sum, out_cout stable in DONE until out_ready=1; out_ready outside DONE has no effect.
REQ-024 SHALL return to IDLE on the edge where out_valid&&out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-025 SHALL ignore changes to in_a/in_b/in_sub/in_cin while not in IDLE.
REQ-026 SHALL wrap modulo 2^(32*NUM_WORDS); overflow reported only via out_cout.

Reset
REQ-027 SHALL on rst_n=0 at a clock edge enter IDLE, clear index, carry, result, out_cout; out_valid=0, busy=0, in_ready=1 after release.
REQ-028 SHALL abort any in-flight operation on reset mid-RUN or mid-DONE without emitting a result.

Structure
REQ-029 SHALL place WORD_W=32 and the FSM state enum in shared package adder_pkg.
REQ-030 SHALL instantiate carry_select_adder_32bit as the sole datapath sub-module; control logic stays in this module.

Verification
REQ-031 Add NUM_WORDS=4, A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, cin=0 -> sum=0x...0001_0000_0000, cout=0, out_valid at cycle 5.
REQ-032 Add A=B=all ones (128b), cin=1 -> sum=all ones, cout=1.
REQ-033 Sub A=5, B=7 -> sum=2^128-2 (0xFFFF...FFFE), cout=0; sub A=7, B=5 -> sum=2, cout=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while toggling in_*, in_valid -> outputs stable, in_ready=0; release -> one transfer, in_ready=1 next cycle.
REQ-035 Assert rst_n=0 in RUN at index 2 -> next cycle IDLE, out_valid=0, result=0; new request completes correctly.
REQ-036 Back-to-back: in_valid held high with 3 requests -> each accepted one cycle after previous out transfer, results in order.
